// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared widths, the r0 constant and grant encoding
// for the register-file write arbiter.
package rf_write_arbiter_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int DEPTH_DEF  = 4;
   localparam int R0         = 0;
   typedef enum logic [2:0] {G_NONE, G_DRAIN, G_A, G_HEAD, G_BYPASS} grant_e;
endpackage

// File: rtl/rf_wq_fifo.sv
// rf_wq_fifo: in-order queue of pending writer-B writes, with parallel
// destination-register compares for A stall and decode hazard checks.
module rf_wq_fifo
   import rf_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_rw,
   input  logic [DATA_W-1:0] push_pw,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_rw,
   output logic [DATA_W-1:0] head_pw,
   output logic              full,
   output logic              empty,
   input  logic [ADDR_W-1:0] a_rw,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   output logic              match_a,
   output logic              match_ra,
   output logic              match_rb
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0] count;
   logic [ADDR_W-1:0] rw_q [DEPTH];
   logic [DATA_W-1:0] pw_q [DEPTH];
   logic [DEPTH-1:0] hit_a, hit_ra, hit_rb;
   assign full = count == FULL_C;
   assign empty = count == '0;
   assign head_rw = rw_q[rd_ptr];
   assign head_pw = pw_q[rd_ptr];
   // an entry is live when its distance from the head is below the count
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [PW-1:0] off;
      logic vld;
      assign off = PW'(i) - rd_ptr;
      assign vld = {1'b0, off} < count;
      assign hit_a[i] = vld & (rw_q[i] == a_rw);
      assign hit_ra[i] = vld & (rw_q[i] == ra);
      assign hit_rb[i] = vld & (rw_q[i] == rb);
   end
   assign match_a = |hit_a;
   assign match_ra = |hit_ra;
   assign match_rb = |hit_rb;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) begin
         rw_q[wr_ptr] <= push_rw;
         pw_q[wr_ptr] <= push_pw;
      end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between pipeline
// writeback (A, priority) and a queued long-latency return path (B).
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_rw,
   input  logic [DATA_W-1:0] a_pw,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_rw,
   input  logic [DATA_W-1:0] b_pw,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   output logic              haz_a,
   output logic              haz_b,
   output logic              rf_en,
   output logic [ADDR_W-1:0] rf_rw,
   output logic [DATA_W-1:0] rf_pw,
   output logic [15:0]       stall_cnt
);
   logic q_full, q_empty, match_a, match_ra, match_rb;
   logic a_nz, b_nz, b_acc, push, pop;
   logic [ADDR_W-1:0] head_rw;
   logic [DATA_W-1:0] head_pw;
   grant_e grant;
   rf_wq_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n),
      .push(push), .push_rw(b_rw), .push_pw(b_pw), .pop(pop),
      .head_rw(head_rw), .head_pw(head_pw), .full(q_full), .empty(q_empty),
      .a_rw(a_rw), .ra(ra), .rb(rb),
      .match_a(match_a), .match_ra(match_ra), .match_rb(match_rb)
   );
   assign a_nz = a_rw != ADDR_W'(R0);
   assign b_nz = b_rw != ADDR_W'(R0);
   assign b_ready = !q_full;
   assign b_acc = b_valid & b_ready;
   // an older queued write to A's register must land before A's
   assign a_ready = !a_valid | !a_nz | (!q_full & !match_a);
   always_comb
      grant = (q_full | (a_valid & match_a)) ? G_DRAIN :
              (a_valid & a_ready & a_nz)    ? G_A :
              !q_empty                      ? G_HEAD :
              (b_acc & b_nz)                ? G_BYPASS : G_NONE;
   assign pop = (grant == G_DRAIN) | (grant == G_HEAD);
   assign push = b_acc & b_nz & (grant != G_BYPASS);
   assign haz_a = (ra != ADDR_W'(R0)) & (match_ra | (rf_en & (rf_rw == ra)));
   assign haz_b = (rb != ADDR_W'(R0)) & (match_rb | (rf_en & (rf_rw == rb)));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rf_en <= 1'b0;
         rf_rw <= '0;
         rf_pw <= '0;
         stall_cnt <= '0;
      end else begin
         rf_en <= grant != G_NONE;
         if (grant == G_A) begin
            rf_rw <= a_rw;
            rf_pw <= a_pw;
         end else if (grant == G_BYPASS) begin
            rf_rw <= b_rw;
            rf_pw <= b_pw;
         end else if (pop) begin
            rf_rw <= head_rw;
            rf_pw <= head_pw;
         end
         if (a_valid && !a_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vectors for bypass, priority, full queue,
// same-register ordering, r0 discard and async reset.
module tb_rf_write_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   logic a_valid = 1'b0, b_valid = 1'b0;
   logic [4:0] a_rw = '0, b_rw = '0, ra = '0, rb = '0;
   logic [31:0] a_pw = '0, b_pw = '0;
   logic a_ready, b_ready, haz_a, haz_b, rf_en;
   logic [4:0] rf_rw;
   logic [31:0] rf_pw;
   logic [15:0] stall_cnt;
   int total = 0, bad = 0;
   rf_write_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_rw(a_rw), .a_pw(a_pw), .a_ready(a_ready),
      .b_valid(b_valid), .b_rw(b_rw), .b_pw(b_pw), .b_ready(b_ready),
      .ra(ra), .rb(rb), .haz_a(haz_a), .haz_b(haz_b),
      .rf_en(rf_en), .rf_rw(rf_rw), .rf_pw(rf_pw), .stall_cnt(stall_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive_a(input logic v, input logic [4:0] rw, input logic [31:0] pw);
      a_valid = v; a_rw = rw; a_pw = pw;
   endtask
   task automatic drive_b(input logic v, input logic [4:0] rw, input logic [31:0] pw);
      b_valid = v; b_rw = rw; b_pw = pw;
   endtask
   task automatic chk_rf(input string tag, input logic en, input logic [4:0] rw, input logic [31:0] pw);
      chk({tag, "_en"}, 32'(rf_en), 32'(en));
      chk({tag, "_rw"}, 32'(rf_rw), 32'(rw));
      chk({tag, "_pw"}, rf_pw, pw);
   endtask
   initial begin
      #12 rst_n = 1'b1;
      step();
      chk("rst_en", 32'(rf_en), 0);
      chk("rst_bready", 32'(b_ready), 1);
      chk("rst_stall", 32'(stall_cnt), 0);
      // bypass
      drive_b(1, 5, 32'h1234); ra = 5;
      #1 chk("byp_bready", 32'(b_ready), 1);
      step();
      drive_b(0, 0, 0);
      chk_rf("byp", 1, 5, 32'h1234);
      #1 chk("byp_haz_rf", 32'(haz_a), 1);
      step();
      chk("byp_idle_en", 32'(rf_en), 0);
      chk("byp_haz_clr", 32'(haz_a), 0);
      // priority: A first, B queued behind it
      drive_a(1, 3, 20); drive_b(1, 7, 99); ra = 7; rb = 3;
      #1 chk("pri_aready", 32'(a_ready), 1);
      chk("pri_haz_same_cycle", 32'(haz_a), 0);
      step();
      drive_a(0, 0, 0); drive_b(0, 0, 0);
      chk_rf("pri_a", 1, 3, 20);
      #1 chk("pri_haz_q", 32'(haz_a), 1);
      chk("pri_hazb_rf", 32'(haz_b), 1);
      step();
      chk_rf("pri_b", 1, 7, 99);
      chk("pri_haz_rf", 32'(haz_a), 1);
      step();
      chk("pri_done_en", 32'(rf_en), 0);
      chk("pri_haz_clr", 32'(haz_a), 0);
      // order: queued B r9 must precede A r9
      drive_a(1, 2, 7); drive_b(1, 9, 1);
      #1 chk("ord_aready0", 32'(a_ready), 1);
      step();
      chk_rf("ord_a2", 1, 2, 7);
      drive_a(1, 9, 2); drive_b(0, 0, 0);
      #1 chk("ord_stall", 32'(a_ready), 0);
      step();
      chk_rf("ord_b9", 1, 9, 1);
      chk("ord_stallcnt", 32'(stall_cnt), 1);
      #1 chk("ord_aready1", 32'(a_ready), 1);
      step();
      chk_rf("ord_a9", 1, 9, 2);
      // full: A busy every cycle, four B writes fill the queue
      for (int i = 0; i < 4; i++) begin
         drive_a(1, 1, 32'(100 + i)); drive_b(1, 5'(8 + i), 32'(200 + i));
         #1 chk($sformatf("full_bready%0d", i), 32'(b_ready), 1);
         step();
         chk($sformatf("full_arf%0d", i), 32'(rf_rw), 1);
      end
      drive_a(1, 1, 104); drive_b(0, 0, 0);
      #1 chk("full_bready_lo", 32'(b_ready), 0);
      chk("full_aready_lo", 32'(a_ready), 0);
      step();
      chk_rf("full_drain8", 1, 8, 200);
      chk("full_stallcnt", 32'(stall_cnt), 2);
      #1 chk("full_aready_hi", 32'(a_ready), 1);
      step();
      chk_rf("full_a", 1, 1, 104);
      drive_a(0, 0, 0);
      for (int i = 1; i < 4; i++) begin
         step();
         chk_rf($sformatf("full_q%0d", i), 1, 5'(8 + i), 32'(200 + i));
      end
      step();
      chk("full_empty_en", 32'(rf_en), 0);
      chk("full_empty_bready", 32'(b_ready), 1);
      // r0 writes are accepted and discarded
      drive_a(1, 0, 55); drive_b(1, 0, 55); ra = 0;
      #1 chk("r0_aready", 32'(a_ready), 1);
      chk("r0_bready", 32'(b_ready), 1);
      chk("r0_haz", 32'(haz_a), 0);
      step();
      chk("r0_en", 32'(rf_en), 0);
      drive_a(0, 0, 0); drive_b(1, 4, 44);
      step();
      drive_b(0, 0, 0);
      chk_rf("r0_qempty_byp", 1, 4, 44);
      // async reset mid-stream with a queued entry and RF_EN high
      drive_a(1, 1, 11); drive_b(1, 6, 66);
      step();
      drive_a(0, 0, 0); drive_b(0, 0, 0);
      chk("rst_pre_en", 32'(rf_en), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_en", 32'(rf_en), 0);
      chk("rst_async_rw", 32'(rf_rw), 0);
      chk("rst_async_bready", 32'(b_ready), 1);
      chk("rst_async_stall", 32'(stall_cnt), 0);
      #2 rst_n = 1'b1;
      step();
      chk("rst_q_flushed", 32'(rf_en), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
